cnn_layer_sequencer: RTL and testbench

//   Run controller for the 3-stage inference chain (conv layer 1 -> conv layer 2 -> dense).

---
 rtl/cnn_layer_sequencer_if.sv | 35 +++
 rtl/cnn_layer_sequencer.sv | 125 ++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_sequencer_if.sv
// Handshake bundle between the host/layer side and the CNN layer sequencer.
//   start, abort     host run request and abort
//   layer_done       done level from each layer (bit 0 = first conv layer)
//   layer_start      one-hot, one-cycle launch pulse to each layer
//   busy             run in progress (launching or awaiting a layer)
//   run_done, error  terminal run status, held until the next start or abort
//   err_layer        index of the layer that timed out
//   cur_layer        index of the layer being launched or awaited
//   cycle_count      cycles spent in the current or last run
// The master modport is the host/layer side; the slave modport is the sequencer.
interface cnn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int CNT_W      = 32
);
  logic                  start;
  logic                  abort;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [NUM_LAYERS-1:0] layer_start;
  logic                  busy;
  logic                  run_done;
  logic                  error;
  logic [1:0]            err_layer;
  logic [1:0]            cur_layer;
  logic [CNT_W-1:0]      cycle_count;

  modport master (
    output start, abort, layer_done,
    input  layer_start, busy, run_done, error, err_layer, cur_layer, cycle_count
  );

  modport slave (
    input  start, abort, layer_done,
    output layer_start, busy, run_done, error, err_layer, cur_layer, cycle_count
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Run controller for a chain of inference layers (conv1 -> conv2 -> dense).
// One accepted host start produces an ordered series of one-cycle layer start
// pulses; each layer is launched only after the previous one reports done.
// A per-layer watchdog moves the run to an error state, and abort returns the
// controller to idle from any state.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous, active-high
//   bus    slave side of cnn_layer_sequencer_if (start/abort/layer_done in,
//          layer_start/busy/run_done/error/err_layer/cur_layer/cycle_count out)
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 32
) (
  input logic                    clock,
  input logic                    reset,
  cnn_layer_sequencer_if.slave   bus
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]         LAST_LAYER = 2'(NUM_LAYERS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [1:0]            cur_layer_q, cur_layer_d;
  logic [1:0]            err_layer_q, err_layer_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]      cycle_count_q, cycle_count_d;
  logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
  logic [NUM_LAYERS-1:0] done_q, done_d;
  logic [NUM_LAYERS-1:0] done_ev;

  // Next-state logic. Abort overrides everything, including a same-cycle
  // start. The launch pulse is computed from the next layer index so that
  // layer_start is a plain register that is high exactly while in LAUNCH.
  always_comb begin
    state_d       = state_q;
    cur_layer_d   = cur_layer_q;
    err_layer_d   = err_layer_q;
    timer_d       = timer_q;
    cycle_count_d = cycle_count_q;
    layer_start_d = '0;
    done_d        = bus.layer_done;
    done_ev       = bus.layer_done & ~done_q;

    if (bus.abort) begin
      state_d     = S_IDLE;
      cur_layer_d = '0;
      timer_d     = '0;
    end else begin
      case (state_q)
        S_IDLE, S_FINISH, S_ERROR: begin
          if (bus.start) begin
            state_d       = S_LAUNCH;
            cur_layer_d   = '0;
            cycle_count_d = '0;
            layer_start_d = NUM_LAYERS'(1);
          end
        end
        S_LAUNCH: begin
          state_d = S_WAIT;
          timer_d = '0;
          if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        S_WAIT: begin
          timer_d = timer_q + TIMER_W'(1);
          if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_W'(1);
          // A done edge in the final watchdog cycle still counts as done.
          if (done_ev[cur_layer_q]) begin
            if (cur_layer_q != LAST_LAYER) begin
              state_d       = S_LAUNCH;
              cur_layer_d   = cur_layer_q + 2'd1;
              layer_start_d = NUM_LAYERS'(1) << (cur_layer_q + 2'd1);
            end else begin
              state_d = S_FINISH;
            end
          end else if (timer_q == TIMER_LAST) begin
            state_d     = S_ERROR;
            err_layer_d = cur_layer_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All controller state, including the registered launch pulse, clears
  // asynchronously so an in-flight pulse drops as soon as reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_layer_q   <= '0;
      err_layer_q   <= '0;
      timer_q       <= '0;
      cycle_count_q <= '0;
      layer_start_q <= '0;
      done_q        <= '0;
    end else begin
      state_q       <= state_d;
      cur_layer_q   <= cur_layer_d;
      err_layer_q   <= err_layer_d;
      timer_q       <= timer_d;
      cycle_count_q <= cycle_count_d;
      layer_start_q <= layer_start_d;
      done_q        <= done_d;
    end
  end

  assign bus.layer_start = layer_start_q;
  assign bus.busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign bus.run_done    = (state_q == S_FINISH);
  assign bus.error       = (state_q == S_ERROR);
  assign bus.err_layer   = err_layer_q;
  assign bus.cur_layer   = cur_layer_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: a table of run vectors, random
// runs checked against a run-level model, plus abort and reset sequences.
module tb_cnn_layer_sequencer;

  localparam int NL   = 3;
  localparam int TO   = 100;
  localparam int CW   = 7;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cnn_layer_sequencer_if #(.NUM_LAYERS(NL), .CNT_W(CW)) bus ();

  cnn_layer_sequencer #(
    .NUM_LAYERS    (NL),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // One run: per-layer done delay (cycles after that layer's start pulse),
  // whether start stays high during the run, whether a stray layer 2 done
  // pulse is injected while layer 0 is awaited, and the expected run result.
  typedef struct {
    int d0, d1, d2;
    bit hold, spur;
    bit exp_done, exp_err;
    int exp_err_layer;
    int exp_count;
  } vec_t;

  // Run-level model results
  int m_n, m_end, m_err_layer, m_count;
  bit m_done, m_err;
  int m_pulse_t[NL];

  // Observed run
  int act_idx[$], act_t[$], act_cur[$];
  int act_end;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Each layer takes d+1 cycles (launch + d waits) if d <= TO; otherwise its
  // watchdog runs TO wait cycles after launch and the run stops there.
  function automatic void modelRun(input int d0, input int d1, input int d2);
    int d[NL];
    int t;
    d = '{d0, d1, d2};
    t = 0; m_n = 0; m_done = 1'b1; m_err = 1'b0; m_err_layer = 0;
    for (int i = 0; i < NL; i++) begin
      m_pulse_t[i] = t;
      m_n = i + 1;
      if (d[i] <= TO) begin
        t += d[i] + 1;
      end else begin
        t += TO + 1;
        m_done = 1'b0;
        m_err = 1'b1;
        m_err_layer = i;
        break;
      end
    end
    m_end = t;
    m_count = (t > CMAX) ? CMAX : t;
  endfunction

  // Drive one run: layer stubs raise done d cycles after seeing their pulse.
  task automatic applyStimulus(input int d0, input int d1, input int d2, input bit hold, input bit spur);
    int d[NL];
    int done_at[NL];
    int t;
    bit finished;
    d = '{d0, d1, d2};
    done_at = '{-1, -1, -1};
    act_idx.delete(); act_t.delete(); act_cur.delete();
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    t = 0;
    finished = 1'b0;
    while (t < 1000 && !finished) begin
      if (bus.layer_start != '0) begin
        checkOutput("pulse onehot", $countones(bus.layer_start), 1);
        for (int i = 0; i < NL; i++) begin
          if (bus.layer_start[i]) begin
            act_idx.push_back(i);
            act_t.push_back(t);
            act_cur.push_back(int'(bus.cur_layer));
            done_at[i] = t + d[i];
            break;
          end
        end
      end
      if (!bus.busy) begin
        finished = 1'b1;
        act_end = t;
        bus.start = 1'b0;
      end
      for (int i = 0; i < NL; i++) begin
        if (done_at[i] == t) bus.layer_done[i] = 1'b1;
        if (done_at[i] >= 0 && t == done_at[i] + 3) bus.layer_done[i] = 1'b0;
      end
      if (spur && t == 3) bus.layer_done[2] = 1'b1;
      if (spur && t == 4) bus.layer_done[2] = 1'b0;
      if (!finished) begin
        tick();
        t++;
      end
    end
    if (!finished) begin
      checkOutput("run cycle budget", t, -1);
      act_end = t;
    end
  endtask

  task automatic runVector(input int d0, input int d1, input int d2, input bit hold, input bit spur,
                           input bit exp_done, input bit exp_err, input int exp_err_layer,
                           input int exp_count, input string name);
    int n;
    modelRun(d0, d1, d2);
    applyStimulus(d0, d1, d2, hold, spur);
    checkOutput({name, " pulse count"}, act_idx.size(), m_n);
    n = (act_idx.size() < m_n) ? act_idx.size() : m_n;
    for (int i = 0; i < n; i++) begin
      checkOutput({name, " pulse index"}, act_idx[i], i);
      checkOutput({name, " pulse time"}, act_t[i], m_pulse_t[i]);
      checkOutput({name, " cur_layer at pulse"}, act_cur[i], i);
    end
    checkOutput({name, " end time"}, act_end, m_end);
    checkOutput({name, " busy"}, bus.busy, 0);
    checkOutput({name, " run_done"}, bus.run_done, exp_done);
    checkOutput({name, " error"}, bus.error, exp_err);
    if (exp_err) checkOutput({name, " err_layer"}, bus.err_layer, exp_err_layer);
    checkOutput({name, " cycle_count"}, bus.cycle_count, exp_count);
    bus.layer_done = '0;
    tick();
    tick();
    checkOutput({name, " no pulse after end"}, bus.layer_start, 0);
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, " layer_start"}, bus.layer_start, 0);
    checkOutput({name, " busy"}, bus.busy, 0);
    checkOutput({name, " run_done"}, bus.run_done, 0);
    checkOutput({name, " error"}, bus.error, 0);
    checkOutput({name, " cur_layer"}, bus.cur_layer, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int quiet;
    int rd[NL];
    bit rhold;

    vecs[0] = '{d0:10,  d1:10,  d2:10,  hold:0, spur:0, exp_done:1, exp_err:0, exp_err_layer:0, exp_count:33};
    vecs[1] = '{d0:10,  d1:200, d2:10,  hold:0, spur:0, exp_done:0, exp_err:1, exp_err_layer:1, exp_count:112};
    vecs[2] = '{d0:100, d1:1,   d2:1,   hold:0, spur:0, exp_done:1, exp_err:0, exp_err_layer:0, exp_count:105};
    vecs[3] = '{d0:20,  d1:5,   d2:5,   hold:1, spur:1, exp_done:1, exp_err:0, exp_err_layer:0, exp_count:33};
    vecs[4] = '{d0:5,   d1:5,   d2:101, hold:0, spur:0, exp_done:0, exp_err:1, exp_err_layer:2, exp_count:113};
    vecs[5] = '{d0:50,  d1:50,  d2:101, hold:1, spur:0, exp_done:0, exp_err:1, exp_err_layer:2, exp_count:127};
    vecs[6] = '{d0:101, d1:1,   d2:1,   hold:0, spur:0, exp_done:0, exp_err:1, exp_err_layer:0, exp_count:101};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.layer_done = '0;
    #12;
    checkIdleOutputs("reset");
    checkOutput("reset err_layer", bus.err_layer, 0);
    checkOutput("reset cycle_count", bus.cycle_count, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      runVector(vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].hold, vecs[v].spur,
                vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_err_layer,
                vecs[v].exp_count, $sformatf("vec%0d", v));
    end

    // Abort out of the error left by the last vector
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkIdleOutputs("abort from error");

    // Abort together with start while awaiting layer 1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("abort seq pulse0", bus.layer_start, 1);
    repeat (4) tick();
    bus.layer_done[0] = 1'b1;
    tick();
    checkOutput("abort seq pulse1", bus.layer_start, 2);
    bus.layer_done[0] = 1'b0;
    repeat (5) tick();
    checkOutput("abort seq busy before", bus.busy, 1);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checkIdleOutputs("abort seq after");
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.layer_start != '0 || bus.busy) quiet++;
    end
    checkOutput("abort seq stays idle", quiet, 0);
    runVector(3, 4, 5, 0, 0, 1, 0, 0, 15, "restart after abort");

    // Asynchronous reset while the first launch pulse is out
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("reset seq pulse0", bus.layer_start, 1);
    #2;
    reset = 1'b1;
    #1;
    checkIdleOutputs("async reset");
    checkOutput("async reset cycle_count", bus.cycle_count, 0);
    tick();
    reset = 1'b0;
    tick();
    runVector(10, 10, 10, 0, 0, 1, 0, 0, 33, "run after reset");

    // Random runs against the run-level model
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NL; i++)
        rd[i] = ($urandom_range(7) == 0) ? int'($urandom_range(105, 95)) : int'($urandom_range(15, 1));
      rhold = 1'($urandom_range(1));
      modelRun(rd[0], rd[1], rd[2]);
      runVector(rd[0], rd[1], rd[2], rhold, 1'b0, m_done, m_err, m_err_layer, m_count,
                $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
